// File: rtl/host_cmd_engine.sv
// Host command engine: decodes UART command bytes to drive DUT reset, clock
// enable and scan chain, and returns scanned-out bytes to the UART transmitter.
module host_cmd_engine #(
    parameter int RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       dut_rstn,
    output logic       dut_clk_en,
    output logic       scan_en,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       idle
);

    localparam logic [7:0] CH_R = 8'h72;
    localparam logic [7:0] CH_O = 8'h6F;
    localparam logic [7:0] CH_G = 8'h67;
    localparam logic [7:0] CH_S = 8'h73;
    localparam logic [7:0] CH_F = 8'h66;
    localparam logic [7:0] CH_D = 8'h64;

    typedef enum logic [3:0] {
        IDLE, RST, LEN_HI, LEN_LO, EXEC, FREE, SO_SHIFT, SO_SEND, SI_WAIT, SI_SHIFT
    } state_t;

    typedef enum logic [1:0] {CMD_EXEC, CMD_SCAN_OUT, CMD_SCAN_IN} cmd_t;

    state_t      state, state_d;
    cmd_t        cmd, cmd_d;
    logic [15:0] cyc_cnt, cyc_cnt_d;
    logic [15:0] byte_cnt, byte_cnt_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  len_hi, len_hi_d;
    logic [7:0]  sr, sr_d;
    logic [7:0]  tx_data_d;
    logic        tx_start_d, dut_rstn_d, clk_en_d, scan_en_d, scan_in_d;
    logic [15:0] len;

    assign len = {len_hi, rx_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= CMD_EXEC;
            cyc_cnt    <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            len_hi     <= '0;
            sr         <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            dut_rstn   <= 1'b1;
            dut_clk_en <= 1'b0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            idle       <= 1'b1;
        end else begin
            state      <= state_d;
            cmd        <= cmd_d;
            cyc_cnt    <= cyc_cnt_d;
            byte_cnt   <= byte_cnt_d;
            bit_cnt    <= bit_cnt_d;
            len_hi     <= len_hi_d;
            sr         <= sr_d;
            tx_data    <= tx_data_d;
            tx_start   <= tx_start_d;
            dut_rstn   <= dut_rstn_d;
            dut_clk_en <= clk_en_d;
            scan_en    <= scan_en_d;
            scan_in    <= scan_in_d;
            idle       <= (state_d == IDLE);
        end
    end

    // Outputs are computed for the next state here and registered above.
    always_comb begin
        state_d    = state;
        cmd_d      = cmd;
        cyc_cnt_d  = cyc_cnt;
        byte_cnt_d = byte_cnt;
        bit_cnt_d  = bit_cnt;
        len_hi_d   = len_hi;
        sr_d       = sr;
        tx_data_d  = tx_data;
        tx_start_d = tx_start;
        dut_rstn_d = dut_rstn;
        clk_en_d   = dut_clk_en;
        scan_en_d  = scan_en;
        scan_in_d  = scan_in;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CH_R: begin
                            state_d    = RST;
                            dut_rstn_d = 1'b0;
                            cyc_cnt_d  = 16'(RST_CYCLES);
                        end
                        CH_O: begin
                            cmd_d   = CMD_EXEC;
                            state_d = LEN_HI;
                        end
                        CH_G: begin
                            cmd_d   = CMD_SCAN_OUT;
                            state_d = LEN_HI;
                        end
                        CH_S: begin
                            cmd_d   = CMD_SCAN_IN;
                            state_d = LEN_HI;
                        end
                        CH_F: begin
                            state_d  = FREE;
                            clk_en_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            RST: begin
                cyc_cnt_d = cyc_cnt - 16'd1;
                if (cyc_cnt == 16'd1) begin
                    state_d    = IDLE;
                    dut_rstn_d = 1'b1;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    if (len == 16'd0) begin
                        state_d = IDLE;
                    end else begin
                        case (cmd)
                            CMD_EXEC: begin
                                state_d   = EXEC;
                                cyc_cnt_d = len;
                                clk_en_d  = 1'b1;
                            end
                            CMD_SCAN_OUT: begin
                                state_d    = SO_SHIFT;
                                byte_cnt_d = len;
                                bit_cnt_d  = '0;
                                scan_en_d  = 1'b1;
                                clk_en_d   = 1'b1;
                            end
                            default: begin
                                state_d    = SI_WAIT;
                                byte_cnt_d = len;
                            end
                        endcase
                    end
                end
            end
            EXEC: begin
                cyc_cnt_d = cyc_cnt - 16'd1;
                if (cyc_cnt == 16'd1) begin
                    state_d  = IDLE;
                    clk_en_d = 1'b0;
                end
            end
            FREE: begin
                if (rx_valid && rx_data == CH_D) begin
                    state_d  = IDLE;
                    clk_en_d = 1'b0;
                end
            end
            SO_SHIFT: begin
                sr_d      = {sr[6:0], scan_out};
                bit_cnt_d = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    state_d   = SO_SEND;
                    scan_en_d = 1'b0;
                    clk_en_d  = 1'b0;
                end
            end
            SO_SEND: begin
                if (!tx_start) begin
                    if (tx_ready) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = sr;
                    end
                end else if (!tx_ready) begin
                    tx_start_d = 1'b0;
                    byte_cnt_d = byte_cnt - 16'd1;
                    if (byte_cnt == 16'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = SO_SHIFT;
                        scan_en_d = 1'b1;
                        clk_en_d  = 1'b1;
                    end
                end
            end
            SI_WAIT: begin
                if (rx_valid) begin
                    state_d   = SI_SHIFT;
                    scan_in_d = rx_data[7];
                    sr_d      = {rx_data[6:0], 1'b0};
                    bit_cnt_d = '0;
                    scan_en_d = 1'b1;
                    clk_en_d  = 1'b1;
                end
            end
            SI_SHIFT: begin
                bit_cnt_d = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    scan_en_d  = 1'b0;
                    clk_en_d   = 1'b0;
                    scan_in_d  = 1'b0;
                    byte_cnt_d = byte_cnt - 16'd1;
                    state_d    = (byte_cnt == 16'd1) ? IDLE : SI_WAIT;
                end else begin
                    scan_in_d = sr[7];
                    sr_d      = {sr[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
